// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin grant of the single writeback port, early rd wakeup,
// register-file write mux in the data phase and a registered commit record for the ROB.
module wb_arbiter #(
   parameter int unsigned UNITS = 4,
   parameter int unsigned DATA  = 32,
   parameter int unsigned RF    = 5,
   parameter int unsigned EXP   = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush_,
   input  logic                    wb_stall,
   input  logic [UNITS-1:0]        req_,
   input  logic [UNITS*RF-1:0]     pre_rd,
   output logic [UNITS-1:0]        ack_,
   input  logic [UNITS-1:0]        wb_e_,
   input  logic [UNITS*RF-1:0]     wb_rd,
   input  logic [UNITS*DATA-1:0]   wb_data,
   input  logic [UNITS-1:0]        wb_exp_,
   input  logic [UNITS*EXP-1:0]    wb_exp_code,
   input  logic [UNITS-1:0]        wb_pred_miss_,
   input  logic [UNITS-1:0]        wb_jump_miss_,
   output logic                    wakeup_e_,
   output logic [RF-1:0]           wakeup_rd,
   output logic                    rf_we_,
   output logic [RF-1:0]           rf_wa,
   output logic [DATA-1:0]         rf_wd,
   output logic                    cm_e_,
   output logic [RF-1:0]           cm_rd,
   output logic                    cm_exp_,
   output logic [EXP-1:0]          cm_exp_code,
   output logic                    cm_pred_miss_,
   output logic                    cm_jump_miss_,
   output logic                    proto_err
);

   localparam int unsigned IW = (UNITS > 1) ? $clog2(UNITS) : 1;

   logic [IW-1:0]   r_rr_ptr;
   logic            r_gnt_v;
   logic [IW-1:0]   r_gnt_idx;
   logic            r_cm_e_;
   logic [RF-1:0]   r_cm_rd;
   logic            r_cm_exp_;
   logic [EXP-1:0]  r_cm_exp_code;
   logic            r_cm_pred_miss_;
   logic            r_cm_jump_miss_;
   logic            r_proto_err;

   logic            w_found;
   logic [IW-1:0]   w_win;
   logic [IW-1:0]   w_cand;
   logic            w_grant;
   logic [IW-1:0]   w_rr_next;
   logic            w_sel_e;
   logic [RF-1:0]   w_sel_rd;
   logic            w_commit;

   // Round-robin search starting at r_rr_ptr
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_cand  = '0;
      for (int unsigned k = 0; k < UNITS; k++) begin
         w_cand = IW'((32'(r_rr_ptr) + k) % UNITS);
         if (!w_found && !req_[w_cand]) begin
            w_found = 1'b1;
            w_win   = w_cand;
         end
      end
   end

   assign w_grant   = w_found && !reset && flush_ && !wb_stall;
   assign w_rr_next = IW'((32'(w_win) + 32'd1) % UNITS);
   assign ack_      = w_grant ? ~(UNITS'(1) << w_win) : '1;
   assign wakeup_e_ = ~w_grant;
   assign wakeup_rd = pre_rd[32'(w_win)*RF +: RF];

   // Data phase: mux the granted unit onto the register-file port
   assign w_sel_e  = !wb_e_[r_gnt_idx];
   assign w_sel_rd = wb_rd[32'(r_gnt_idx)*RF +: RF];
   assign w_commit = r_gnt_v && w_sel_e && flush_;
   assign rf_we_   = ~(w_commit && (w_sel_rd != '0));
   assign rf_wa    = w_sel_rd;
   assign rf_wd    = wb_data[32'(r_gnt_idx)*DATA +: DATA];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rr_ptr        <= '0;
         r_gnt_v         <= 1'b0;
         r_gnt_idx       <= '0;
         r_cm_e_         <= 1'b1;
         r_cm_rd         <= '0;
         r_cm_exp_       <= 1'b1;
         r_cm_exp_code   <= '0;
         r_cm_pred_miss_ <= 1'b1;
         r_cm_jump_miss_ <= 1'b1;
         r_proto_err     <= 1'b0;
      end else begin
         r_gnt_v     <= w_grant;
         r_proto_err <= r_gnt_v && !w_sel_e && flush_;
         if (w_grant) begin
            r_rr_ptr  <= w_rr_next;
            r_gnt_idx <= w_win;
         end
         // Flags fall back to inactive whenever no record is committed
         if (w_commit) begin
            r_cm_e_         <= 1'b0;
            r_cm_rd         <= w_sel_rd;
            r_cm_exp_       <= wb_exp_[r_gnt_idx];
            r_cm_exp_code   <= wb_exp_code[32'(r_gnt_idx)*EXP +: EXP];
            r_cm_pred_miss_ <= wb_pred_miss_[r_gnt_idx];
            r_cm_jump_miss_ <= wb_jump_miss_[r_gnt_idx];
         end else begin
            r_cm_e_         <= 1'b1;
            r_cm_exp_       <= 1'b1;
            r_cm_pred_miss_ <= 1'b1;
            r_cm_jump_miss_ <= 1'b1;
         end
      end
   end

   assign cm_e_         = r_cm_e_;
   assign cm_rd         = r_cm_rd;
   assign cm_exp_       = r_cm_exp_;
   assign cm_exp_code   = r_cm_exp_code;
   assign cm_pred_miss_ = r_cm_pred_miss_;
   assign cm_jump_miss_ = r_cm_jump_miss_;
   assign proto_err     = r_proto_err;

endmodule
